// File: rtl/cpu_dispatch.sv
// cpu_dispatch: decode / dispatch / writeback stage in front of cpu_ula.
// Takes one instruction per handshake, reads operands from an 8-entry register file,
// pulses the ALU op code for one cycle, waits for done (bounded by TIMEOUT) and writes
// the result back. LDI, NOP and HALT finish without touching the ALU.
// Build option: define CPU_DISPATCH_RETIRE_CNT_EN to add the o_retire_count port.
module cpu_dispatch #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_instr_valid,
    input  logic [15:0]       i_instr,
    output logic              o_instr_ready,
    output logic [2:0]        o_alu_op_code,
    output logic [DATA_W-1:0] o_alu_src1,
    output logic [DATA_W-1:0] o_alu_src2,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_done,
    output logic              o_wb_valid,
    output logic [2:0]        o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    input  logic [2:0]        i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data,
    output logic              o_halted,
    output logic              o_error
`ifdef CPU_DISPATCH_RETIRE_CNT_EN
    ,
    output logic [15:0]       o_retire_count
`endif
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SUBI = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;
    localparam int         CNT_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_ISSUE, S_WAIT, S_WB, S_HALTED
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [15:0]       r_instr;
    logic [DATA_W-1:0] r_rf [8];
    logic [DATA_W-1:0] r_src1, r_src2, r_result;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_halted, r_error;

    logic [2:0]        w_op, w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0] w_rs1_val, w_rs2_val, w_imm7, w_imm10;
    logic              w_timeout;

    assign w_op      = r_instr[15:13];
    assign w_rd      = r_instr[12:10];
    assign w_rs1     = r_instr[9:7];
    assign w_rs2     = r_instr[6:4];
    assign w_imm7    = DATA_W'(r_instr[6:0]);
    assign w_imm10   = DATA_W'(r_instr[9:0]);
    // r0 is hardwired to zero on every read port
    assign w_rs1_val = (w_rs1 == 3'd0) ? '0 : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 3'd0) ? '0 : r_rf[w_rs2];
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    assign o_alu_src1 = r_src1;
    assign o_alu_src2 = r_src2;
    assign o_wb_addr  = w_rd;
    assign o_wb_data  = r_result;
    assign o_dbg_data = (i_dbg_addr == 3'd0) ? '0 : r_rf[i_dbg_addr];
    assign o_halted   = r_halted;
    assign o_error    = r_error;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic and state-decoded outputs; op code is only nonzero in ISSUE
    always_comb begin
        w_state_nxt   = r_state;
        o_instr_ready = 1'b0;
        o_alu_op_code = OP_NOP;
        o_wb_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_instr_ready = 1'b1;
                if (i_instr_valid) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (w_op)
                    OP_NOP:  w_state_nxt = S_IDLE;
                    OP_LDI:  w_state_nxt = S_WB;
                    OP_HALT: w_state_nxt = S_HALTED;
                    default: w_state_nxt = S_ISSUE;
                endcase
            end
            S_ISSUE: begin
                o_alu_op_code = w_op;
                w_state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (i_alu_done)     w_state_nxt = S_WB;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_WB: begin
                o_wb_valid  = (w_rd != 3'd0);
                w_state_nxt = S_IDLE;
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: instruction latch, operand capture, timeout counter, result and rf write
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instr  <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_halted <= 1'b0;
            r_error  <= 1'b0;
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_instr_valid) r_instr <= i_instr;
                end
                S_DECODE: begin
                    // operands are sampled here, so rd may alias rs1/rs2 safely
                    r_src1 <= w_rs1_val;
                    r_src2 <= (w_op == OP_ADDI || w_op == OP_SUBI) ? w_imm7 : w_rs2_val;
                    if (w_op == OP_LDI)  r_result <= w_imm10;
                    if (w_op == OP_HALT) r_halted <= 1'b1;
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (i_alu_done)     r_result <= i_alu_result;
                    else if (w_timeout) r_error  <= 1'b1;
                    else                r_cnt    <= r_cnt + CNT_W'(1);
                end
                S_WB: begin
                    if (w_rd != 3'd0) r_rf[w_rd] <= r_result;
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_DISPATCH_RETIRE_CNT_EN
    logic [15:0] r_retire_cnt;
    assign o_retire_count = r_retire_cnt;

    // Retired-instruction counter: register writes and completed NOPs, wraps naturally
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_retire_cnt <= '0;
        else if (o_wb_valid || (r_state == S_DECODE && w_op == OP_NOP))
            r_retire_cnt <= r_retire_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_cpu_dispatch.sv
// Bench for cpu_dispatch: stimulus pushes expected writebacks and ALU requests into
// queues from a sequential-semantics register model; a negedge monitor pops and compares.
// A small cpu_ula stand-in answers op codes after a per-instruction latency.
module tb_cpu_dispatch;
    localparam int DW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_instr_valid;
    logic [15:0]   i_instr;
    logic          o_instr_ready;
    logic [2:0]    o_alu_op_code;
    logic [DW-1:0] o_alu_src1, o_alu_src2;
    logic [DW-1:0] i_alu_result = '0;
    logic          i_alu_done = 1'b0;
    logic          o_wb_valid;
    logic [2:0]    o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic [2:0]    i_dbg_addr;
    logic [DW-1:0] o_dbg_data;
    logic          o_halted, o_error;
`ifdef CPU_DISPATCH_RETIRE_CNT_EN
    logic [15:0]   o_retire_count;
`endif

    always #5 clk = ~clk;

    cpu_dispatch #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_instr_valid(i_instr_valid), .i_instr(i_instr), .o_instr_ready(o_instr_ready),
        .o_alu_op_code(o_alu_op_code), .o_alu_src1(o_alu_src1), .o_alu_src2(o_alu_src2),
        .i_alu_result(i_alu_result), .i_alu_done(i_alu_done),
        .o_wb_valid(o_wb_valid), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
        .o_halted(o_halted), .o_error(o_error)
`ifdef CPU_DISPATCH_RETIRE_CNT_EN
        , .o_retire_count(o_retire_count)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ALU behaviour: imm operand bit6 is a sign flag, bits[5:0] the magnitude
    function automatic logic [DW-1:0] ula(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        logic [DW-1:0] m;
        m = DW'(b[5:0]);
        case (op)
            3'd1:    return a + b;
            3'd3:    return a - b;
            3'd5:    return DW'(a * b);
            3'd2:    return b[6] ? a - m : a + m;
            3'd4:    return b[6] ? a + m : a - m;
            default: return '0;
        endcase
    endfunction

    typedef struct { logic [2:0] addr; logic [DW-1:0] data; int at; } wb_t;
    typedef struct { logic [2:0] op; logic [DW-1:0] a; logic [DW-1:0] b; } alu_t;

    logic [DW-1:0] mrf [8];
    wb_t           wbq [$];
    alu_t          aluq[$];
    int            latq[$];
    int            cur_lat  = 1;
    bit            stray_en = 0;

    // cpu_ula stand-in; latency 0 means "never answer"
    logic          busy = 1'b0;
    int            acnt = 0;
    logic [2:0]    aop;
    logic [DW-1:0] aa, ab;
    always @(posedge clk) begin : ula_model
        int l;
        l = 0;
        i_alu_done <= 1'b0;
        if (rst) begin
            busy <= 1'b0;
        end else if (o_alu_op_code != 3'd0) begin
            if (latq.size() > 0) l = latq.pop_front();
            busy <= (l != 0);
            acnt <= l;
            aop  <= o_alu_op_code;
            aa   <= o_alu_src1;
            ab   <= o_alu_src2;
        end else if (busy) begin
            if (acnt == 1) begin
                i_alu_done   <= 1'b1;
                i_alu_result <= ula(aop, aa, ab);
                busy         <= 1'b0;
            end else begin
                acnt <= acnt - 1;
            end
        end else if (stray_en && $urandom_range(7) == 0) begin
            i_alu_done   <= 1'b1;
            i_alu_result <= DW'($urandom);
        end
    end

    // Monitor: writebacks and ALU requests against the queued expectations
    logic [2:0] prev_op = 3'd0;
    always @(negedge clk) begin : mon
        wb_t  e;
        alu_t q;
        if (!rst) begin
            if (o_wb_valid) begin
                if (wbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wb_unexpected: got addr %0d data 0x%0h, expected no write",
                             o_wb_addr, o_wb_data);
                end else begin
                    e = wbq.pop_front();
                    check("wb_addr", 32'(o_wb_addr), 32'(e.addr));
                    check("wb_data", 32'(o_wb_data), 32'(e.data));
                    check("wb_cycle", cyc, e.at);
                end
            end
            if (o_alu_op_code != 3'd0) begin
                check("op_one_cycle", 32'(prev_op), 32'd0);
                if (aluq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL alu_unexpected: got op %0d, expected none", o_alu_op_code);
                end else begin
                    q = aluq.pop_front();
                    check("alu_op", 32'(o_alu_op_code), 32'(q.op));
                    check("alu_src1", 32'(o_alu_src1), 32'(q.a));
                    check("alu_src2", 32'(o_alu_src2), 32'(q.b));
                end
            end
            prev_op = o_alu_op_code;
        end else begin
            prev_op = 3'd0;
        end
    end

    // Wait for IDLE, then hand one instruction over and update the reference model
    task automatic issue(input logic [15:0] ins, output int acc);
        logic [2:0]    op, rd;
        logic [DW-1:0] a, b, r;
        int            n;
        op  = ins[15:13];
        rd  = ins[12:10];
        acc = 0;
        n   = 0;
        @(negedge clk);
        while (!o_instr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_instr_ready) begin
            bound_fail("ready_wait");
            return;
        end
        acc = cyc;
        a = mrf[ins[9:7]];
        b = (op == 3'd2 || op == 3'd4) ? DW'(ins[6:0]) : mrf[ins[6:4]];
        case (op)
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5: begin
                aluq.push_back('{op, a, b});
                latq.push_back(cur_lat);
                r = ula(op, a, b);
                if (cur_lat != 0 && rd != 3'd0) begin
                    wbq.push_back('{rd, r, acc + 4 + cur_lat});
                    mrf[rd] = r;
                end
            end
            3'd6: begin
                r = DW'(ins[9:0]);
                if (rd != 3'd0) begin
                    wbq.push_back('{rd, r, acc + 2});
                    mrf[rd] = r;
                end
            end
            default: ;
        endcase
        i_instr_valid = 1'b1;
        i_instr       = ins;
        @(negedge clk);
        i_instr_valid = 1'b0;
        i_instr       = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((!o_instr_ready || wbq.size() != 0) && n < 300);
        if (n >= 300) bound_fail("idle_wait");
    endtask

    task automatic dbg_read(input logic [2:0] a, output logic [DW-1:0] d);
        i_dbg_addr = a;
        #1;
        d = o_dbg_data;
    endtask

    task automatic check_rf(input string tag);
        logic [DW-1:0] d;
        for (int i = 0; i < 8; i++) begin
            dbg_read(3'(i), d);
            check($sformatf("%s_r%0d", tag, i), 32'(d), 32'(mrf[i]));
        end
    endtask

    // Hold reset across one edge and check the cleared state while it is still asserted
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst           = 1'b1;
        i_instr_valid = 1'b0;
        wbq.delete();
        aluq.delete();
        latq.delete();
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        @(negedge clk);
        check({tag, "_ready"},  32'(o_instr_ready), 32'd1);
        check({tag, "_op"},     32'(o_alu_op_code), 32'd0);
        check({tag, "_wbv"},    32'(o_wb_valid),    32'd0);
        check({tag, "_wba"},    32'(o_wb_addr),     32'd0);
        check({tag, "_wbd"},    32'(o_wb_data),     32'd0);
        check({tag, "_src1"},   32'(o_alu_src1),    32'd0);
        check({tag, "_src2"},   32'(o_alu_src2),    32'd0);
        check({tag, "_halted"}, 32'(o_halted),      32'd0);
        check({tag, "_error"},  32'(o_error),       32'd0);
        check_rf(tag);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction
    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [6:0] imm);
        return {op, rd, rs1, imm};
    endfunction
    function automatic logic [15:0] enc_l(input logic [2:0] rd, input logic [9:0] imm);
        return {3'd6, rd, imm};
    endfunction

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int            acc, n;
        logic [DW-1:0] d;
        rst           = 1'b1;
        i_instr_valid = 1'b0;
        i_instr       = '0;
        i_dbg_addr    = '0;
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        repeat (2) @(negedge clk);
        do_reset("rst0");

        // LDI / ADD with fixed single-cycle ALU latency
        cur_lat = 1;
        issue(enc_l(3'd1, 10'd5), acc);
        issue(enc_l(3'd2, 10'd7), acc);
        issue(enc_r(3'd1, 3'd3, 3'd1, 3'd2), acc);
        wait_idle();
        dbg_read(3'd3, d);
        check("add_r3", 32'(d), 32'd12);

        // immediate forms with the sign flag
        issue(enc_i(3'd4, 3'd4, 3'd1, 7'h43), acc);
        issue(enc_i(3'd2, 3'd5, 3'd1, 7'h02), acc);
        wait_idle();
        dbg_read(3'd4, d);
        check("subi_r4", 32'(d), 32'd8);
        dbg_read(3'd5, d);
        check("addi_r5", 32'(d), 32'd7);

        // MUL truncation and writes to r0
        issue(enc_l(3'd1, 10'h100), acc);
        issue(enc_l(3'd2, 10'h101), acc);
        issue(enc_r(3'd5, 3'd6, 3'd1, 3'd2), acc);
        issue(enc_l(3'd0, 10'd9), acc);
        wait_idle();
        dbg_read(3'd6, d);
        check("mul_r6", 32'(d), 32'h0100);
        dbg_read(3'd0, d);
        check("r0_zero", 32'(d), 32'd0);

        // randomized program with stray done pulses while the ALU is idle
        stray_en = 1;
        for (int k = 0; k < 60; k++) begin
            cur_lat = $urandom_range(1, 4);
            issue({3'($urandom_range(0, 6)), 13'($urandom)}, acc);
        end
        wait_idle();
        check_rf("rand");

        // ALU never answers: abort after TIMEOUT wait cycles, no write
        stray_en = 0;
        cur_lat  = 0;
        issue(enc_r(3'd1, 3'd7, 3'd1, 3'd2), acc);
        n = 0;
        while (!o_error && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!o_error) bound_fail("error_wait");
        else check("timeout_cycles", cyc - acc, TO + 3);
        wait_idle();
        check("timeout_ready", 32'(o_instr_ready), 32'd1);
        check_rf("tmo");
        cur_lat = 2;
        issue(enc_r(3'd3, 3'd7, 3'd1, 3'd2), acc);
        wait_idle();
        check("error_sticky", 32'(o_error), 32'd1);
        check_rf("after_tmo");

        // reset while waiting on the ALU
        cur_lat = 4;
        issue(enc_r(3'd1, 3'd3, 3'd1, 3'd2), acc);
        n = 0;
        while (o_alu_op_code == 3'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (o_alu_op_code == 3'd0) bound_fail("op_wait");
        do_reset("rstw");
        repeat (6) @(negedge clk);
        check("rstw_idle_ready", 32'(o_instr_ready), 32'd1);

        // HALT, then keep offering an instruction
        cur_lat = 1;
        issue(enc_l(3'd1, 10'h055), acc);
        issue({3'd7, 13'd0}, acc);
        i_instr_valid = 1'b1;
        i_instr       = enc_l(3'd2, 10'h3FF);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("halt_ready", 32'(o_instr_ready), 32'd0);
        end
        check("halt_flag", 32'(o_halted), 32'd1);
        check_rf("halt");
        i_instr_valid = 1'b0;
        do_reset("rsth");

        check("wbq_drained", 32'(wbq.size()), 32'd0);
        check("aluq_drained", 32'(aluq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
